// File: rtl/n_bit_serial_subtractor.sv
// rtl/n_bit_serial_subtractor.sv - multi-cycle chunked subtractor computing A - B - Bin
// CHUNK bits are processed per clock, LSB chunk first, with the borrow carried between cycles.
module n_bit_serial_subtractor #(
  parameter int WIDTH = 30,
  parameter int CHUNK = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt;
  logic             borrow;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] a_chunk, b_chunk, d;
  logic             b_out;
  logic             last;
  logic             accept;
  logic             ovf_chunk;
  int               base;

  always_comb begin
    base    = int'(idx) * CHUNK;
    a_chunk = a_reg[base +: CHUNK];
    b_chunk = b_reg[base +: CHUNK];
    {b_out, d} = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow};
    acc_nxt = acc;
    acc_nxt[base +: CHUNK] = d;
    // Only meaningful on the MSB chunk: operand signs differ and the result sign flipped.
    ovf_chunk = (a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1]) & (d[CHUNK-1] ^ a_chunk[CHUNK-1]);
  end

  assign last   = (idx == IW'(NCHUNK - 1));
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
      Ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg  <= A;
        b_reg  <= B;
        borrow <= Bin;
        idx    <= '0;
        acc    <= '0;
      end else if (state == RUN) begin
        acc    <= acc_nxt;
        borrow <= b_out;
        idx    <= last ? '0 : idx + 1'b1;
        if (last) begin
          Diff <= acc_nxt;
          Bout <= b_out;
          Ovf  <= ovf_chunk;
        end
      end
    end
  end

endmodule
